// File: rtl/fetch_stage_buf_pkg.sv
// Shared constants and helpers for the fetch stage and its FIFOs.
package fetch_stage_buf_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fetch_stage_buf_sync_fifo.sv
// Single-clock FIFO with flush; push is accepted when full only if a pop happens in the same cycle.
module sync_fifo
    import fetch_stage_buf_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage_buf.sv
// Instruction fetch stage: issues in-order memory requests, tags them with their PC and
// buffers responses for Decode; redirects flush the queue and discard in-flight responses.
module fetch_stage_buf
    import fetch_stage_buf_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0],
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_d,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            valid_d,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d
);

    localparam int CW = clog2(FQ_DEPTH) + 1;
    localparam int QW = 32 + XLEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   q_count, tag_count;
    logic [QW-1:0]   q_rdata;
    logic [XLEN-1:0] tag_rdata;
    logic            room_ok, req_fire, rsp_ok, rsp_push, q_pop;

    always_comb begin
        room_ok        = ({1'b0, q_count} + {1'b0, outstanding_q}) < (CW+1)'(FQ_DEPTH);
        imem_req_valid = room_ok && !redirect_valid && !rst;
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses with nothing tracked in flight are protocol errors and are dropped.
        rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
        rsp_push       = rsp_ok && (discard_q == '0) && (tag_count != '0) && !redirect_valid;
        q_pop          = valid_d && !stall_d && !redirect_valid;
        outstanding_d  = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
        fetch_pc_d     = fetch_pc_q;
        discard_d      = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (req_fire),
        .wdata (fetch_pc_q),
        .pop   (rsp_push),
        .rdata (tag_rdata),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(QW), .DEPTH(FQ_DEPTH)) u_instr_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (rsp_push),
        .wdata ({imem_rsp_data, tag_rdata}),
        .pop   (q_pop),
        .rdata (q_rdata),
        .count (q_count)
    );

    always_comb begin
        imem_req_addr = fetch_pc_q;
        valid_d       = (q_count != '0);
        instr_d       = valid_d ? q_rdata[QW-1:XLEN] : NOP_INSTR;
        pc_d          = valid_d ? q_rdata[XLEN-1:0] : '0;
        pc_plus4_d    = valid_d ? (q_rdata[XLEN-1:0] + XLEN'(4)) : '0;
    end

endmodule

// File: tb/tb_fetch_stage_buf.sv
// Bench for fetch_stage_buf: directed scenarios plus randomized traffic against an
// in-order memory model and an expected-PC-stream reference.
module tb_fetch_stage_buf;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic            clk, rst;
    logic            redirect_valid, stall_d;
    logic [31:0]     redirect_pc;
    logic            imem_req_valid, imem_req_ready;
    logic [31:0]     imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            valid_d;
    logic [31:0]     instr_d, pc_d, pc_plus4_d;

    int          total, fails, cyc, last_due;
    logic [31:0] exp_pc, exp_req;
    logic        prev_redirect;
    mreq_t       mem_q[$];
    logic        obs_req_valid, obs_fire, obs_valid_d, obs_rsp;
    logic [31:0] obs_addr, obs_pc_d;

    fetch_stage_buf #(.XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc        = RPC;
        exp_req       = RPC;
        prev_redirect = 1'b0;
        mem_q.delete();
        last_due      = cyc;
    endtask

    // Asserts rst between clock edges and checks the outputs clear before any edge.
    task automatic apply_reset(input int hold);
        #2;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall_d        = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_valid_d", {31'b0, valid_d}, 32'd0);
        check("rst_instr_d", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_pc_plus4_d", pc_plus4_d, 32'd0);
        model_reset();
        repeat (hold) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0;
        last_due = cyc;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic do_cycle(input logic stall, input logic ready, input logic redir,
                            input logic [31:0] rpc, input int lat_lo, input int lat_hi);
        int    lat;
        int    due;
        mreq_t m;
        stall_d        = stall;
        imem_req_ready = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        obs_req_valid = imem_req_valid;
        obs_addr      = imem_req_addr;
        obs_valid_d   = valid_d;
        obs_pc_d      = pc_d;
        obs_rsp       = imem_rsp_valid;
        obs_fire      = imem_req_valid && ready;
        if (valid_d) begin
            check("pc_d", pc_d, exp_pc);
            check("instr_d", instr_d, mem_word(exp_pc));
            check("pc_plus4_d", pc_plus4_d, exp_pc + 32'd4);
        end else begin
            check("idle_instr_d", instr_d, NOP);
            check("idle_pc_d", pc_d, 32'd0);
            check("idle_pc_plus4_d", pc_plus4_d, 32'd0);
        end
        if (prev_redirect) check("valid_after_redirect", {31'b0, valid_d}, 32'd0);
        if (redir) check("req_valid_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
        if (obs_fire) check("outstanding_bound", {31'b0, mem_q.size() < DEPTH}, 32'd1);
        if (valid_d && !stall && !redir) exp_pc = exp_pc + 32'd4;
        if (redir) begin
            exp_pc  = rpc & ~32'd3;
            exp_req = rpc & ~32'd3;
        end else if (obs_fire) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr = imem_req_addr;
            m.due  = due;
            mem_q.push_back(m);
            exp_req = exp_req + 32'd4;
        end
        prev_redirect = redir;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic        vd[6];
        logic        rv[6];
        logic [31:0] ad[6];
        logic [31:0] pcs[6];
        int          fires, pops;
        logic        found;
        logic [31:0] first_pc;

        total = 0; fails = 0; cyc = 0;
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        model_reset();

        // Reset state, first request at RESET_PC, wrap past all-ones, 2-cycle fill latency.
        apply_reset(2);
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 1);
            vd[i] = obs_valid_d; rv[i] = obs_req_valid; ad[i] = obs_addr; pcs[i] = obs_pc_d;
        end
        check("first_req_valid", {31'b0, rv[0]}, 32'd1);
        check("first_req_addr", ad[0], 32'hFFFF_FFF8);
        check("second_req_addr", ad[1], 32'hFFFF_FFFC);
        check("wrap_req_addr", ad[2], 32'h0000_0000);
        check("no_valid_cycle1", {31'b0, vd[1]}, 32'd0);
        check("valid_cycle2", {31'b0, vd[2]}, 32'd1);
        check("first_pc_d", pcs[2], 32'hFFFF_FFF8);
        check("third_pc_d", pcs[4], 32'h0000_0000);

        // Stalled decode: exactly FQ_DEPTH requests, then one new request per pop.
        apply_reset(2);
        fires = 0;
        repeat (10) begin
            do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, 1);
            if (obs_fire) fires++;
        end
        check("stall_fire_count", fires, 32'd4);
        check("stall_req_valid_low", {31'b0, obs_req_valid}, 32'd0);
        fires = 0;
        repeat (8) begin
            do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 1);
            if (obs_fire) fires++;
        end
        check("release_fire_count", fires, 32'd7);

        // Redirect with three requests in flight.
        apply_reset(2);
        for (int i = 0; i < 20; i++) begin
            if (mem_q.size() == 3) break;
            do_cycle(1'b1, 1'b1, 1'b0, 32'd0, 4, 4);
        end
        check("three_in_flight", mem_q.size(), 32'd3);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 4, 4);
        do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 4, 4);
        check("redirect_req_addr", obs_addr, 32'h0000_0100);
        check("redirect_req_valid", {31'b0, obs_req_valid}, 32'd1);
        found = 1'b0; first_pc = '0;
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 4, 4);
            if (obs_valid_d) begin
                found = 1'b1; first_pc = obs_pc_d;
                break;
            end
        end
        check("redirect_first_valid_seen", {31'b0, found}, 32'd1);
        check("redirect_first_pc", first_pc, 32'h0000_0100);

        // Redirect in the same cycle as a push and a pop.
        apply_reset(2);
        repeat (5) do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 1);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1, 1);
        check("push_pop_redirect_rsp", {31'b0, obs_rsp}, 32'd1);
        check("push_pop_redirect_valid", {31'b0, obs_valid_d}, 32'd1);
        do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 1);
        check("queue_empty_after_redirect", {31'b0, obs_valid_d}, 32'd0);
        repeat (6) do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 1);

        // Randomized traffic with an asynchronous reset mid-burst.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                apply_reset(1);
                do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 1);
                check("restart_req_valid", {31'b0, obs_req_valid}, 32'd1);
                check("restart_req_addr", obs_addr, RPC);
            end
            do_cycle(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 25) == 0,
                     $urandom, 1, 4);
        end

        pops = 0;
        repeat (20) begin
            do_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, 2);
            if (obs_valid_d) pops++;
        end
        check("drain_progress", {31'b0, pops >= 10}, 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage_buf.md
FETCH_STAGE_BUF -- requirements
Module: fetch_stage_buf

Interface
REQ-001 Parameter XLEN, default 32, PC and address width; legal values are 32 and 64.
REQ-002 Parameter RESET_PC, default 0, PC loaded on reset; bits [1:0] SHALL be 0.
REQ-003 Parameter FQ_DEPTH, default 4, fetch-queue entries and maximum outstanding requests; power of 2, at least 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 redirect_valid  in  1  taken branch/jump from Execute.
REQ-007 redirect_pc  in  XLEN  redirect target.
REQ-008 stall_d  in  1  Decode cannot accept an instruction this cycle.
REQ-009 imem_req_valid  out  1  fetch request valid.
REQ-010 imem_req_addr  out  XLEN  fetch address.
REQ-011 imem_req_ready  in  1  memory accepts request.
REQ-012 imem_rsp_valid  in  1  response valid; responses return in request order, latency of 1 or more cycles.
REQ-013 imem_rsp_data  in  32  instruction word.
REQ-014 valid_d  out  1  Decode outputs hold a valid instruction.
REQ-015 instr_d  out  32  instruction to Decode.
REQ-016 pc_d  out  XLEN  PC of instr_d.
REQ-017 pc_plus4_d  out  XLEN  pc_d + 4.

Function
REQ-018 Fetch PC register SHALL advance by 4 on each accepted request (imem_req_valid & imem_req_ready); addition is modulo 2^XLEN, so all-ones minus 3 wraps to 0.
REQ-019 imem_req_valid SHALL be 1 only when queue_count + outstanding < FQ_DEPTH and redirect_valid = 0.
REQ-020 imem_req_addr SHALL equal the fetch PC register and SHALL stay stable while valid & !ready, except on redirect.
REQ-021 On redirect_valid = 1, the block SHALL in the same cycle:
- drop imem_req_valid;
- load the fetch PC with {redirect_pc[XLEN-1:2], 2'b00};
- empty the queue;
- set discard_count to the current outstanding count, excluding any response arriving this cycle.
REQ-022 While discard_count > 0, each imem_rsp_valid SHALL decrement discard_count and SHALL NOT be written to the queue.
REQ-023 Otherwise each imem_rsp_valid SHALL push {data, pc} into the queue, with pc taken from an in-order PC tag FIFO of depth FQ_DEPTH.
REQ-024 Queue head SHALL drive instr_d, pc_d and pc_plus4_d; valid_d = (queue_count != 0).
REQ-025 Pop SHALL occur when valid_d & !stall_d.
REQ-026 Push and pop in the same cycle SHALL leave the count unchanged; this includes the full condition.
REQ-027 Minimum latency is 1 cycle: a response accepted in cycle N SHALL appear on valid_d in cycle N+1; there is no combinational bypass.
REQ-028 While valid_d = 1 and stall_d = 1, instr_d, pc_d and pc_plus4_d SHALL hold.
REQ-029 Redirect SHALL take priority over push, pop and request in the same cycle; valid_d SHALL be 0 in the following cycle.
REQ-030 When valid_d = 0, instr_d SHALL read 32'h00000013 (NOP) and pc_d/pc_plus4_d SHALL read 0.
REQ-031 Overflow is impossible by REQ-019; a response with no tracked outstanding request is a protocol error and SHALL be ignored.

Reset
REQ-032 rst = 1 SHALL immediately, without waiting for clk, set:
- fetch PC = RESET_PC;
- queue, tag FIFO, outstanding and discard_count = 0;
- valid_d = 0 and imem_req_valid = 0.
REQ-033 First request SHALL issue on the first rising edge after rst deasserts, with addr = RESET_PC.
REQ-034 Reset asserted mid-operation SHALL abandon in-flight requests; the memory side is reset by the same rst.

Structure
REQ-035 A shared package SHALL hold:
- NOP encoding 32'h00000013;
- default XLEN;
- default RESET_PC;
- function clog2 for counter widths.
REQ-036 Counters outstanding and discard_count SHALL be clog2(FQ_DEPTH)+1 bits wide.
REQ-037 One sub-module, sync_fifo (parametrised width/depth), SHALL be instantiated twice: the instruction queue (32+XLEN) and the PC tag FIFO (XLEN).

Verification
REQ-038 Reset, then rsp 1 cycle after each req, stall_d = 0 -> addrs 0,4,8,...; valid_d from cycle 2; pc_d sequence 0,4,8; pc_plus4_d = pc_d+4.
REQ-039 FQ_DEPTH = 4, stall_d held 1, ready = 1 -> exactly 4 requests, then imem_req_valid = 0; release stall -> one new request per pop.
REQ-040 3 requests outstanding, redirect_pc = 0x103 -> next addr 0x100; 3 stale responses discarded; first valid_d shows pc_d = 0x100.
REQ-041 Redirect in the same cycle as push and pop -> queue empty; valid_d = 0 next cycle; no stale instruction ever reaches Decode.
REQ-042 XLEN = 32, RESET_PC = 0xFFFFFFFC -> addrs 0xFFFFFFFC then 0x00000000.
REQ-043 rst pulsed asynchronously mid-burst -> outputs cleared before the next clk edge; restart at RESET_PC.
